// File: rtl/warp_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : warp_scheduler
// Purpose  : Multi-warp compute-unit scheduler. Walks the CU through IDLE,
//            FETCH, DECODE, REQ, WAIT, EXECUTE, WRITEBACK and DONE while
//            keeping a private PC and done flag per warp. After every
//            instruction it hands the pipeline to the next live warp in
//            round-robin order.
// Ports    : clk, reset (async, active-high)
//            cu_enable, warp_enable_mask      - start request / warps to run
//            is_*                             - decoder flags
//            fetch_state, lsu_state           - fetcher / per-lane LSU states
//            next_pc                          - PC unit result for curr_warp
//            curr_pc, curr_warp               - pipeline owner and its PC
//            rf_ren, rf_wen, mem_ren, mem_wen - registered enables
//            cu_state, warp_done, cu_complete - status
// Revision : 1.0 - initial release
// ============================================================================
module warp_scheduler #(
  parameter int PC_ADDR_WIDTH = 8,
  parameter int CU_WIDTH      = 4,
  parameter int NUM_WARPS     = 4,
  localparam int WARP_ID_WIDTH = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cu_enable,
  input  logic [NUM_WARPS-1:0]     warp_enable_mask,
  input  logic                     is_alu,
  input  logic                     is_branch,
  input  logic                     is_const,
  input  logic                     is_load,
  input  logic                     is_store,
  input  logic                     is_nop,
  input  logic                     is_jr,
  input  logic [1:0]               fetch_state,
  input  logic [2*CU_WIDTH-1:0]    lsu_state,
  input  logic [PC_ADDR_WIDTH-1:0] next_pc,
  output logic [PC_ADDR_WIDTH-1:0] curr_pc,
  output logic [WARP_ID_WIDTH-1:0] curr_warp,
  output logic                     rf_ren,
  output logic                     rf_wen,
  output logic                     mem_ren,
  output logic                     mem_wen,
  output logic [3:0]               cu_state,
  output logic [NUM_WARPS-1:0]     warp_done,
  output logic                     cu_complete
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_REQ       = 4'd3,
    S_WAIT      = 4'd4,
    S_EXECUTE   = 4'd5,
    S_WRITEBACK = 4'd6,
    S_DONE      = 4'd7
  } state_t;

  state_t                     state_q, state_d;
  logic [PC_ADDR_WIDTH-1:0]   pc_q [NUM_WARPS];
  logic [PC_ADDR_WIDTH-1:0]   pc_d [NUM_WARPS];
  logic [WARP_ID_WIDTH-1:0]   curr_warp_q, curr_warp_d;
  logic [NUM_WARPS-1:0]       warp_done_q, warp_done_d;
  logic                       rf_ren_q, rf_ren_d;
  logic                       rf_wen_q, rf_wen_d;
  logic                       mem_ren_q, mem_ren_d;
  logic                       mem_wen_q, mem_wen_d;
  logic                       cu_complete_q, cu_complete_d;

  logic                       lsu_busy;
  logic [WARP_ID_WIDTH-1:0]   first_warp;
  logic [NUM_WARPS-1:0]       done_post;
  logic                       next_found;
  logic [WARP_ID_WIDTH-1:0]   next_warp;
  logic [WARP_ID_WIDTH-1:0]   srch_idx;

  // A nop raises no enable; it is recognised purely by the other flags being low.
  logic unused_is_nop;
  assign unused_is_nop = is_nop;

  // Lanes in REQ (1) or WAIT (2) hold the pipeline; idle (0) and done (3) do not.
  always_comb begin
    lsu_busy = 1'b0;
    for (int i = 0; i < CU_WIDTH; i++) begin
      if (lsu_state[2*i +: 2] == 2'd1 || lsu_state[2*i +: 2] == 2'd2) begin
        lsu_busy = 1'b1;
      end
    end
  end

  // Lowest enabled warp starts the run (descending loop: last hit wins).
  always_comb begin
    first_warp = '0;
    for (int i = NUM_WARPS - 1; i >= 0; i--) begin
      if (warp_enable_mask[i]) begin
        first_warp = WARP_ID_WIDTH'(i);
      end
    end
  end

  // Done flags as they will be after this WRITEBACK; the search must see a
  // warp retiring on jr as already finished.
  always_comb begin
    done_post = warp_done_q;
    if (is_jr) begin
      done_post[curr_warp_q] = 1'b1;
    end
  end

  // Round-robin search from curr_warp+1 around to curr_warp itself. Offsets
  // are scanned from largest to smallest so the nearest live warp wins.
  always_comb begin
    next_found = 1'b0;
    next_warp  = '0;
    srch_idx   = '0;
    for (int k = NUM_WARPS; k >= 1; k--) begin
      srch_idx = WARP_ID_WIDTH'((int'(curr_warp_q) + k) % NUM_WARPS);
      if (!done_post[srch_idx]) begin
        next_found = 1'b1;
        next_warp  = srch_idx;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    curr_warp_d   = curr_warp_q;
    warp_done_d   = warp_done_q;
    rf_ren_d      = rf_ren_q;
    rf_wen_d      = rf_wen_q;
    mem_ren_d     = mem_ren_q;
    mem_wen_d     = mem_wen_q;
    cu_complete_d = cu_complete_q;

    case (state_q)
      S_IDLE: begin
        if (cu_enable) begin
          if (|warp_enable_mask) begin
            for (int i = 0; i < NUM_WARPS; i++) begin
              pc_d[i] = '0;
            end
            warp_done_d = ~warp_enable_mask;
            curr_warp_d = first_warp;
            state_d     = S_FETCH;
          end else begin
            state_d       = S_DONE;
            cu_complete_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (fetch_state == 2'd3) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d   = S_REQ;
        rf_ren_d  = is_load | is_store | is_alu | is_branch;
        rf_wen_d  = is_load | is_alu | is_const;
        mem_ren_d = is_load;
        mem_wen_d = is_store;
      end
      S_REQ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!lsu_busy) begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        rf_ren_d    = 1'b0;
        rf_wen_d    = 1'b0;
        mem_ren_d   = 1'b0;
        mem_wen_d   = 1'b0;
        warp_done_d = done_post;
        if (!is_jr) begin
          pc_d[curr_warp_q] = next_pc;
        end
        if (next_found) begin
          curr_warp_d = next_warp;
          state_d     = S_FETCH;
        end else begin
          state_d       = S_DONE;
          cu_complete_d = 1'b1;
        end
      end
      S_DONE: begin
        if (!cu_enable) begin
          state_d       = S_IDLE;
          cu_complete_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      for (int i = 0; i < NUM_WARPS; i++) begin
        pc_q[i] <= '0;
      end
      curr_warp_q   <= '0;
      warp_done_q   <= '1;
      rf_ren_q      <= 1'b0;
      rf_wen_q      <= 1'b0;
      mem_ren_q     <= 1'b0;
      mem_wen_q     <= 1'b0;
      cu_complete_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      curr_warp_q   <= curr_warp_d;
      warp_done_q   <= warp_done_d;
      rf_ren_q      <= rf_ren_d;
      rf_wen_q      <= rf_wen_d;
      mem_ren_q     <= mem_ren_d;
      mem_wen_q     <= mem_wen_d;
      cu_complete_q <= cu_complete_d;
    end
  end

  assign curr_pc     = pc_q[curr_warp_q];
  assign curr_warp   = curr_warp_q;
  assign rf_ren      = rf_ren_q;
  assign rf_wen      = rf_wen_q;
  assign mem_ren     = mem_ren_q;
  assign mem_wen     = mem_wen_q;
  assign cu_state    = state_q;
  assign warp_done   = warp_done_q;
  assign cu_complete = cu_complete_q;

endmodule
`default_nettype wire

// File: tb/tb_warp_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_warp_scheduler
// Purpose  : Self-checking bench for warp_scheduler. A reference model builds
//            the expected instruction stream (warp, PC, flags, duration) for
//            each run; the driver replays it and a monitor pops and compares
//            at every FETCH entry and during REQ..WRITEBACK.
// Revision : 1.0 - initial release
// ============================================================================
module tb_warp_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       cu_enable;
  logic [3:0] warp_enable_mask;
  logic       is_alu, is_branch, is_const, is_load, is_store, is_nop, is_jr;
  logic [1:0] fetch_state;
  logic [7:0] lsu_state;
  logic [7:0] next_pc;
  logic [7:0] curr_pc;
  logic [1:0] curr_warp;
  logic       rf_ren, rf_wen, mem_ren, mem_wen;
  logic [3:0] cu_state;
  logic [3:0] warp_done;
  logic       cu_complete;

  always #5 clk = ~clk;

  warp_scheduler dut (
    .clk(clk), .reset(reset), .cu_enable(cu_enable),
    .warp_enable_mask(warp_enable_mask),
    .is_alu(is_alu), .is_branch(is_branch), .is_const(is_const),
    .is_load(is_load), .is_store(is_store), .is_nop(is_nop), .is_jr(is_jr),
    .fetch_state(fetch_state), .lsu_state(lsu_state), .next_pc(next_pc),
    .curr_pc(curr_pc), .curr_warp(curr_warp),
    .rf_ren(rf_ren), .rf_wen(rf_wen), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .cu_state(cu_state), .warp_done(warp_done), .cu_complete(cu_complete)
  );

  typedef struct {
    int warp; int pc;
    bit alu; bit branch; bit cst; bit load; bit store; bit nop; bit jr;
    int npc; int fw; int lw; int lane; int cycles;
  } instr_t;

  instr_t stim_q[$];
  instr_t exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     exp_tot;
  int     tot_cyc;
  bit     mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: plays the round-robin schedule with plain arrays.
  // mode 0 random, 1 jr on 3rd instr, 2 load then jr on 2nd, 3 warp1 jr first.
  task automatic gen(input logic [3:0] m, input int mode);
    bit     done[4];
    int     pc[4];
    int     cnt[4];
    int     cur, nxt, kind;
    instr_t r;
    exp_tot = 0;
    for (int w = 0; w < 4; w++) begin done[w] = !m[w]; pc[w] = 0; cnt[w] = 0; end
    cur = -1;
    for (int w = 3; w >= 0; w--) if (m[w]) cur = w;
    while (cur >= 0) begin
      r = '{default:0};
      r.warp = cur; r.pc = pc[cur]; cnt[cur]++;
      case (mode)
        0: r.jr = (cnt[cur] >= 4) || ($urandom_range(0, 3) == 0);
        1: r.jr = (cnt[cur] == 3);
        2: r.jr = (cnt[cur] == 2);
        default: r.jr = (cnt[cur] == ((cur == 1) ? 1 : 3));
      endcase
      if (!r.jr) begin
        kind = (mode == 0) ? int'($urandom_range(0, 5)) : ((mode == 2) ? 3 : 5);
        case (kind)
          0: r.alu = 1; 1: r.branch = 1; 2: r.cst = 1;
          3: r.load = 1; 4: r.store = 1; default: r.nop = 1;
        endcase
      end
      r.fw   = (mode == 0) ? int'($urandom_range(0, 3)) : 0;
      r.lw   = (mode == 0) ? int'($urandom_range(0, 4)) : ((mode == 2 && !r.jr) ? 5 : 0);
      r.lane = (mode == 0) ? int'($urandom_range(0, 3)) : 2;
      r.npc  = (mode == 0) ? int'($urandom_range(0, 255)) : ((pc[cur] + 1) % 256);
      r.cycles = 6 + r.fw + r.lw;
      exp_tot += r.cycles;
      stim_q.push_back(r);
      exp_q.push_back(r);
      if (r.jr) done[cur] = 1; else pc[cur] = r.npc;
      nxt = -1;
      for (int k = 1; k <= 4; k++) if (!done[(cur + k) % 4] && nxt < 0) nxt = (cur + k) % 4;
      cur = nxt;
    end
  endtask

  // Monitor: pops the expected instruction whenever the DUT enters FETCH.
  instr_t     cur_exp;
  logic [3:0] mst_prev = 4'd0;
  int         icyc = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (cu_state == 4'd1 && mst_prev != 4'd1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_instr: got warp %0d expected no instruction", curr_warp);
        end else begin
          cur_exp = exp_q.pop_front();
          chk("fetch_warp", 32'(curr_warp), cur_exp.warp);
          chk("fetch_pc", 32'(curr_pc), cur_exp.pc);
          chk("fetch_enables", 32'({rf_ren, rf_wen, mem_ren, mem_wen}), 0);
        end
        icyc = 0;
      end
      if (cu_state >= 4'd1 && cu_state <= 4'd6) begin icyc++; tot_cyc++; end
      if (cu_state >= 4'd3 && cu_state <= 4'd6)
        chk("enables", 32'({rf_ren, rf_wen, mem_ren, mem_wen}),
            32'({cur_exp.load | cur_exp.store | cur_exp.alu | cur_exp.branch,
                 cur_exp.load | cur_exp.alu | cur_exp.cst, cur_exp.load, cur_exp.store}));
      if (cu_state == 4'd6) begin
        chk("wb_warp", 32'(curr_warp), cur_exp.warp);
        chk("wb_pc", 32'(curr_pc), cur_exp.pc);
        chk("instr_cycles", icyc, cur_exp.cycles);
      end
      mst_prev = cu_state;
    end else begin
      mst_prev = 4'd0;
    end
  end

  task automatic run(input logic [3:0] m, input int mode);
    instr_t     s;
    logic [3:0] st, pst;
    logic [7:0] lv;
    int         fcnt, lcnt;
    bit         fin;
    stim_q.delete(); exp_q.delete();
    gen(m, mode);
    tot_cyc = 0; mon_en = 1'b1;
    @(negedge clk);
    warp_enable_mask = m; cu_enable = 1'b1;
    pst = 4'd0; fin = 1'b0; fcnt = 0; lcnt = 0; s = '{default:0};
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      st = cu_state;
      if (n == 0) chk("start_state", 32'(st), (m != 0) ? 1 : 7);
      if (st == 4'd7) begin fin = 1'b1; break; end
      if (st == 4'd1 && pst != 4'd1) begin
        if (stim_q.size() > 0) s = stim_q.pop_front();
        {is_alu, is_branch, is_const, is_load, is_store, is_nop, is_jr} =
          {s.alu, s.branch, s.cst, s.load, s.store, s.nop, s.jr};
        next_pc = 8'(s.npc); fcnt = 0; lcnt = 0;
      end
      fetch_state = (st == 4'd1 && fcnt >= s.fw) ? 2'd3 : 2'($urandom_range(0, 2));
      if (st == 4'd1) fcnt++;
      lv = 8'($urandom);
      if (st == 4'd4) begin
        for (int i = 0; i < 4; i++) lv[2*i +: 2] = ($urandom_range(0, 1) != 0) ? 2'd3 : 2'd0;
        if (lcnt < s.lw) lv[2*s.lane +: 2] = (lcnt < 3) ? 2'd1 : 2'd2;
        lcnt++;
      end
      lsu_state = lv;
      if (mode == 0) begin
        cu_enable = 1'($urandom_range(0, 1));
        warp_enable_mask = 4'($urandom);
      end
      pst = st;
    end
    cu_enable = 1'b1;
    chk("run_reaches_done", 32'(fin), 1);
    if (fin) begin
      chk("done_complete", 32'(cu_complete), 1);
      chk("done_warp_done", 32'(warp_done), 4'hF);
      chk("exp_queue_empty", exp_q.size(), 0);
      chk("total_cycles", tot_cyc, exp_tot);
      @(negedge clk);
      chk("done_hold_state", 32'(cu_state), 7);
      chk("done_hold_complete", 32'(cu_complete), 1);
      cu_enable = 1'b0;
      @(negedge clk);
      chk("idle_state", 32'(cu_state), 0);
      chk("idle_complete", 32'(cu_complete), 0);
      chk("idle_warp_done_kept", 32'(warp_done), 4'hF);
    end else begin
      cu_enable = 1'b0; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
    end
    mon_en = 1'b0;
  endtask

  initial begin
    bit found;
    reset = 1'b1; cu_enable = 1'b0; warp_enable_mask = 4'd0;
    {is_alu, is_branch, is_const, is_load, is_store, is_nop, is_jr} = 7'd0;
    fetch_state = 2'd0; lsu_state = 8'd0; next_pc = 8'd0;
    repeat (2) @(negedge clk);
    chk("reset_state", 32'(cu_state), 0);
    chk("reset_pc", 32'(curr_pc), 0);
    chk("reset_warp", 32'(curr_warp), 0);
    chk("reset_warp_done", 32'(warp_done), 4'hF);
    chk("reset_enables", 32'({rf_ren, rf_wen, mem_ren, mem_wen}), 0);
    chk("reset_complete", 32'(cu_complete), 0);
    reset = 1'b0;

    // Asynchronous reset in the WAIT of warp 0's second instruction.
    warp_enable_mask = 4'hF; cu_enable = 1'b1; fetch_state = 2'd3;
    is_alu = 1'b1; next_pc = 8'd5; found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (cu_state == 4'd4 && curr_pc == 8'd5) begin found = 1'b1; break; end
    end
    chk("async_reach_wait", 32'(found), 1);
    chk("async_enables_before", 32'({rf_ren, rf_wen, mem_ren, mem_wen}), 4'b1100);
    #2 reset = 1'b1;
    #1;
    chk("async_state", 32'(cu_state), 0);
    chk("async_pc", 32'(curr_pc), 0);
    chk("async_warp", 32'(curr_warp), 0);
    chk("async_enables", 32'({rf_ren, rf_wen, mem_ren, mem_wen}), 0);
    chk("async_warp_done", 32'(warp_done), 4'hF);
    @(negedge clk);
    reset = 1'b0; cu_enable = 1'b0; is_alu = 1'b0;

    run(4'b0101, 1);
    chk("interleave_36_cycles", tot_cyc, 36);
    run(4'b1000, 1);
    run(4'b0100, 2);
    run(4'b0111, 3);
    run(4'b0000, 0);
    for (int i = 0; i < 20; i++) run(4'($urandom_range(0, 15)), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/warp_scheduler.md
# warp_scheduler

Multi-warp successor to the single-PC compute-unit scheduler. It sequences the CU through the same eight stages, from IDLE through FETCH, DECODE, REQ, WAIT, EXECUTE and WRITEBACK to DONE, but keeps an independent PC and done flag for up to NUM_WARPS warps. It interleaves warps round-robin at instruction granularity. It sits between the decoder/fetcher/LSUs and the PC unit/register files, and drives `curr_pc`/`curr_warp` to the fetcher and PC unit.

## Interface
- PC_ADDR_WIDTH, 8, PC width
- CU_WIDTH, 4, lanes (LSUs) per CU
- NUM_WARPS, 4, warp contexts (≥1); WARP_ID_WIDTH = max(1, $clog2(NUM_WARPS)) derived localparam
- clk  in  1  clock
- reset  in  1  asynchronous, active-high; one clock, all state in `clk` domain
- cu_enable  in  1  start request (level)
- warp_enable_mask  in  NUM_WARPS  warps to run; sampled in IDLE only
- is_alu, is_branch, is_const, is_load, is_store, is_nop, is_jr  in  1 each  decoder flags, valid from DECODE onward
- fetch_state  in  2  fetcher state (3 = FT_DONE)
- lsu_state  in  2*CU_WIDTH  packed LSU states, lane i at [2i+1:2i]; 1 = REQ, 2 = WAIT
- next_pc  in  PC_ADDR_WIDTH  PC unit result for current warp, valid in WRITEBACK
- curr_pc  out  PC_ADDR_WIDTH  PC of `curr_warp` (combinational mux of PC array)
- curr_warp  out  WARP_ID_WIDTH  warp owning the pipeline
- rf_ren, rf_wen, mem_ren, mem_wen  out  1 each  registered enables
- cu_state  out  4  IDLE=0, FETCH=1, DECODE=2, REQ=3, WAIT=4, EXECUTE=5, WRITEBACK=6, DONE=7
- warp_done  out  NUM_WARPS  per-warp done flags
- cu_complete  out  1  all enabled warps finished

## Operation
- Reset (async): state IDLE, all PCs 0, curr_warp 0, warp_done all 1, enables 0, cu_complete 0.
- IDLE: on cu_enable=1:
  - mask≠0: all PCs←0; warp_done←~mask; curr_warp←lowest set bit; →FETCH.
  - mask=0: →DONE, cu_complete←1.
- FETCH: hold until fetch_state==3, then →DECODE.
- DECODE: →REQ; rf_ren←load|store|alu|branch; rf_wen←load|alu|const; mem_ren←load; mem_wen←store.
- REQ: →WAIT.
- WAIT: stay while any lane's lsu_state is 1 or 2; otherwise →EXECUTE. Lanes in 0 or 3 count as ready.
- EXECUTE: →WRITEBACK.
- WRITEBACK: all four enables←0.
  - is_jr: warp_done[curr_warp]←1, PC unchanged.
  - else: PC[curr_warp]←next_pc.
  - Then select the next warp: first index not done, searched curr_warp+1, +2, … wrapping modulo NUM_WARPS and ending at curr_warp itself. The search uses the post-update done flags.
  - If found: curr_warp←it, →FETCH. The same warp is chosen again if it is the only one live.
  - If none: →DONE, cu_complete←1.
- DONE: hold cu_complete=1 while cu_enable=1. On cu_enable=0: →IDLE, cu_complete←0; warp_done retained until next start.
- cu_enable deasserted outside IDLE/DONE: ignored; the run continues.
- Branch divergence within a warp is not handled; one next_pc per warp.
- Non-selected warps' PCs are never written.

## Timing
- Start: cu_enable sampled high in IDLE → cu_state=1 next cycle.
- Minimum instruction: 6 cycles (FETCH 1, DECODE, REQ, WAIT 1, EXECUTE, WRITEBACK). Each extra FETCH cycle and each extra WAIT cycle adds one.
- Enables rise on the cycle cu_state becomes REQ. They hold through WAIT/EXECUTE/WRITEBACK and fall on the cycle leaving WRITEBACK.
- curr_warp/PC switch is visible in the same cycle cu_state returns to FETCH.
- cu_complete rises in the same cycle cu_state becomes DONE.
- Reset asserted mid-instruction: outputs go to reset values immediately (asynchronous), without waiting for clk.

## Test plan
- Reset mid-WAIT with mask=4'b1111 running → cu_state=0, curr_pc=0, enables 0, warp_done=4'b1111 without waiting for clk.
- mask=4'b0101, fetch_state=3 always, LSUs idle, next_pc=PC+1, is_jr on each warp's 3rd instruction → curr_warp sequence 0,2,0,2,0,2; each instruction 6 cycles; cu_complete after 36 cycles in FETCH..WRITEBACK; warp_done=4'b1111.
- mask=4'b1000 → first curr_warp=3. Single live warp reselected each WRITEBACK; PC[3] increments 0,1,2 before is_jr.
- is_load instruction with lane 2 lsu_state=1 for 3 cycles, then 2 for 2 cycles, then 3 → WAIT lasts 6 cycles. rf_ren=rf_wen=mem_ren=1 and mem_wen=0 from REQ through WRITEBACK.
- mask=0 with cu_enable=1 → DONE and cu_complete=1 next cycle. Drop cu_enable → IDLE, cu_complete=0.
- mask=4'b0111, warp 1 executes jr first → round-robin skips warp 1: 0,1,2,0,2,0,…
